// File: rtl/knn_data_feeder.sv
// Training-sample store and sequencer feeding knn_system: loads labelled vectors plus a query,
// then serves one stored sample per distance_calculator request edge until the store is exhausted.
module knn_data_feeder #(
    parameter int W            = 16,
    parameter int MAX_ELEMENTS = 32,
    parameter int TYPE_W       = 3,
    parameter int L            = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      load_is_query,
    input  logic [W*MAX_ELEMENTS-1:0] load_data,
    input  logic [TYPE_W-1:0]         load_type,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      data_request,
    output logic [W*MAX_ELEMENTS-1:0] training_data,
    output logic [TYPE_W-1:0]         training_data_type,
    output logic [W*MAX_ELEMENTS-1:0] input_data,
    output logic                      read_done,
    output logic                      busy,
    output logic                      pass_done,
    output logic                      overflow,
    output logic [L:0]                sample_count
);

    localparam int VW    = W * MAX_ELEMENTS;
    localparam int DEPTH = 1 << L;
    localparam logic [L:0] FULL = {1'b1, {L{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [L-1:0]         wr_ptr;
    logic [L:0]           rd_ptr;
    logic                 query_loaded;
    logic                 req_q;
    logic [TYPE_W+VW-1:0] mem [DEPTH];

    logic full;
    logic req_edge;
    logic do_query, do_write, do_overflow, do_clear, do_start, do_read, do_finish;

    assign full     = (sample_count == FULL);
    assign req_edge = data_request & ~req_q;
    assign busy     = (state != S_IDLE);

    // Handshake: a load beat transfers on any cycle where load_valid && load_ready;
    // load_ready is high only in IDLE. A query beat or clear never blocks the handshake.
    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        do_query    = 1'b0;
        do_write    = 1'b0;
        do_overflow = 1'b0;
        do_clear    = 1'b0;
        do_start    = 1'b0;
        do_read     = 1'b0;
        do_finish   = 1'b0;
        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                do_clear   = clear;
                if (load_valid && !clear) begin
                    if (load_is_query)  do_query    = 1'b1;
                    else if (full)      do_overflow = 1'b1;
                    else                do_write    = 1'b1;
                end
                // Start sees the pre-load count and query flag of this cycle.
                if (start && !clear && full && query_loaded) begin
                    do_start   = 1'b1;
                    state_next = S_FIRST;
                end
            end
            S_FIRST: begin
                do_read    = 1'b1;
                state_next = S_SERVE;
            end
            S_SERVE: begin
                if (req_edge) begin
                    if (rd_ptr < FULL) begin
                        do_read = 1'b1;
                    end else begin
                        do_finish  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            sample_count       <= '0;
            query_loaded       <= 1'b0;
            overflow           <= 1'b0;
            read_done          <= 1'b0;
            pass_done          <= 1'b0;
            req_q              <= 1'b0;
            training_data      <= '0;
            training_data_type <= '0;
            input_data         <= '0;
        end else begin
            state     <= state_next;
            read_done <= do_read;
            pass_done <= do_finish;
            // Idle keeps req_q low; FIRST samples the live request so a level held
            // across start does not count as a fresh edge in SERVE.
            req_q     <= (state == S_IDLE) ? 1'b0 : data_request;
            if (do_query) begin
                input_data   <= load_data;
                query_loaded <= 1'b1;
            end
            if (do_clear) begin
                wr_ptr       <= '0;
                sample_count <= '0;
                overflow     <= 1'b0;
            end else if (do_write) begin
                wr_ptr       <= wr_ptr + 1'b1;
                sample_count <= sample_count + 1'b1;
            end
            if (do_overflow) overflow <= 1'b1;
            if (do_start) rd_ptr <= '0;
            if (do_read) begin
                {training_data_type, training_data} <= mem[rd_ptr[L-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage has no reset; an empty sample_count makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {load_type, load_data};
    end

endmodule

// File: tb/tb_knn_data_feeder.sv
// Directed-sequence bench for knn_data_feeder with random payloads checked against a queue model.
module tb_knn_data_feeder;
    localparam int W = 16, MAX_ELEMENTS = 32, TYPE_W = 3, L = 6;
    localparam int VW = W * MAX_ELEMENTS;
    localparam int DEPTH = 1 << L;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic              load_is_query = 1'b0;
    logic [VW-1:0]     load_data = '0;
    logic [TYPE_W-1:0] load_type = '0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              data_request = 1'b0;
    logic [VW-1:0]     training_data;
    logic [TYPE_W-1:0] training_data_type;
    logic [VW-1:0]     input_data;
    logic              read_done;
    logic              busy;
    logic              pass_done;
    logic              overflow;
    logic [L:0]        sample_count;

    always #5 clk = ~clk;

    knn_data_feeder #(.W(W), .MAX_ELEMENTS(MAX_ELEMENTS), .TYPE_W(TYPE_W), .L(L)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_is_query(load_is_query), .load_data(load_data), .load_type(load_type),
        .clear(clear), .start(start), .data_request(data_request),
        .training_data(training_data), .training_data_type(training_data_type),
        .input_data(input_data), .read_done(read_done), .busy(busy), .pass_done(pass_done),
        .overflow(overflow), .sample_count(sample_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: stored samples in load order, plus status flags.
    logic [VW-1:0]     exp_data[$];
    logic [TYPE_W-1:0] exp_type[$];
    logic [VW-1:0]     m_query = '0;
    bit                m_query_loaded = 1'b0;
    bit                m_overflow = 1'b0;
    int                rd_idx = 0;
    int                pulses = 0;
    int                pass_cnt = 0;

    always @(negedge clk) begin
        if (read_done) pulses++;
        if (pass_done) pass_cnt++;
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input bit is_query, input logic [TYPE_W-1:0] t,
                             input logic [VW-1:0] d, input bit clr);
        load_valid = 1'b1; load_is_query = is_query; load_type = t; load_data = d; clear = clr;
        check("load_ready", load_ready, 1);
        tick();
        load_valid = 1'b0; clear = 1'b0;
        if (clr) begin
            exp_data.delete(); exp_type.delete(); m_overflow = 1'b0;
        end else if (is_query) begin
            m_query = d; m_query_loaded = 1'b1;
        end else if (exp_data.size() < DEPTH) begin
            exp_data.push_back(d); exp_type.push_back(t);
        end else begin
            m_overflow = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, sample_count, exp_data.size());
        check({tag, "_overflow"}, overflow, m_overflow);
        check({tag, "_query"}, input_data, m_query);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_start(input string tag);
        bit accept;
        accept = (exp_data.size() == DEPTH) && m_query_loaded;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, accept);
        check({tag, "_rd0"}, read_done, 0);
        if (accept) begin
            tick();
            check({tag, "_first_rd"}, read_done, 1);
            check({tag, "_first_data"}, training_data, exp_data[0]);
            check({tag, "_first_type"}, training_data_type, exp_type[0]);
            rd_idx = 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check({tag, "_idle_busy"}, busy, 0);
                check({tag, "_idle_rd"}, read_done, 0);
            end
        end
    endtask

    task automatic serve_edge(input int gap);
        data_request = 1'b1;
        tick();
        data_request = 1'b0;
        check("serve_query_stable", input_data, m_query);
        if (rd_idx < DEPTH) begin
            check("serve_rd", read_done, 1);
            check("serve_data", training_data, exp_data[rd_idx]);
            check("serve_type", training_data_type, exp_type[rd_idx]);
            check("serve_pass_early", pass_done, 0);
            rd_idx++;
        end else begin
            check("finish_rd", read_done, 0);
            check("finish_pass", pass_done, 1);
            check("finish_busy", busy, 0);
        end
        for (int k = 0; k < gap; k++) begin
            tick();
            check("gap_rd", read_done, 0);
            check("gap_pass", pass_done, 0);
            check("gap_hold", training_data, exp_data[rd_idx-1]);
        end
    endtask

    initial begin
        int p0;
        int pc0;
        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_rd", read_done, 0);
        check("rst_count", sample_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tdata", training_data, 0);
        check("rst_query", input_data, 0);
        rst_n = 1'b1;
        tick();

        // Full store but no query: start must be ignored
        for (int i = 0; i < DEPTH; i++) load_beat(0, TYPE_W'(i % 8), rand_vec(), 0);
        check_status("full_noquery");
        do_start("start_noquery");

        // 65th beat is dropped and sets overflow
        load_beat(0, 3'd5, rand_vec(), 0);
        check_status("overflow");
        check("overflow_set", overflow, 1);

        load_beat(1, 3'd0, rand_vec(), 0);
        check_status("query");

        // Full pass, request edges spaced 5 cycles
        p0 = pulses;
        pc0 = pass_cnt;
        do_start("pass1");
        for (int i = 0; i < DEPTH; i++) serve_edge(4);
        tick();
        check("pass1_pulses", pulses - p0, DEPTH);
        check("pass1_pass_cnt", pass_cnt - pc0, 1);
        check("pass1_pass_pulse", pass_done, 0);
        check_status("after_pass1");

        // Rerun with a held request: only one extra read_done
        do_start("pass2");
        data_request = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("held_rd", read_done, (k == 0));
            if (k == 0) check("held_data", training_data, exp_data[1]);
        end
        data_request = 1'b0;
        rd_idx = 2;
        tick();
        check("held_release_rd", read_done, 0);
        for (int i = 2; i <= DEPTH; i++) serve_edge(1);
        check_status("after_pass2");

        // Asynchronous reset mid-pass at rd_ptr = 10
        pc0 = pass_cnt;
        do_start("pass3");
        for (int i = 0; i < 9; i++) serve_edge(1);
        check("pre_reset_rdidx", rd_idx, 10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd", read_done, 0);
        check("abort_count", sample_count, 0);
        check("abort_pass", pass_done, 0);
        check("abort_query", input_data, 0);
        exp_data.delete(); exp_type.delete();
        m_query = '0; m_query_loaded = 1'b0; m_overflow = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_pass", pass_cnt - pc0, 0);
        check_status("after_abort");

        // 63 samples with query: start ignored
        for (int i = 0; i < DEPTH - 1; i++) load_beat(0, TYPE_W'($urandom_range(0, 7)), rand_vec(), 0);
        load_beat(1, 3'd0, rand_vec(), 0);
        check_status("count63");
        do_start("start_63");

        // Fill and overflow, then clear with same-cycle beat
        load_beat(0, 3'd1, rand_vec(), 0);
        load_beat(0, 3'd2, rand_vec(), 0);
        check_status("refull");
        load_beat(0, 3'd4, rand_vec(), 1);
        check_status("clear");
        check("clear_count0", sample_count, 0);

        // Reload and run a full pass with random spacing
        for (int i = 0; i < DEPTH; i++) load_beat(0, TYPE_W'($urandom_range(0, 7)), rand_vec(), 0);
        check_status("reload");
        p0 = pulses;
        do_start("pass4");
        for (int i = 0; i < DEPTH; i++) serve_edge($urandom_range(1, 4));
        tick();
        check("pass4_pulses", pulses - p0, DEPTH);
        check_status("after_pass4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
